// File: rtl/rx_align_pkg.sv
// Shared types and constants for the 60-bit receive word aligner.
// The window helper is used by the top level and the marker detector.
package rx_align_pkg;

   localparam int unsigned WORD_W   = 60;
   localparam int unsigned OFFSET_W = 6;
   localparam int unsigned CAT_W    = 2 * WORD_W;
   localparam int unsigned CNT_W    = 4;

   localparam logic [WORD_W-1:0] MARKER_DEFAULT = 60'hA5F0C396E1D27B4;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } align_state_e;

   // Window k of the {cur, prev} concatenation; prev occupies bits [59:0].
   function automatic logic [WORD_W-1:0] window_at(input logic [CAT_W-1:0]    cat,
                                                   input logic [OFFSET_W-1:0] k);
      return WORD_W'(cat >> k);
   endfunction

endpackage

// File: rtl/rx_marker_detector.sv
// Combinational search of all 60 candidate windows for the alignment marker.
// Reports whether any window matches and the lowest matching offset.
module rx_marker_detector
   import rx_align_pkg::*;
#(
   parameter logic [WORD_W-1:0] MARKER = MARKER_DEFAULT
) (
   input  logic [CAT_W-1:0]    cat_i,
   output logic                hit_any_c_o,
   output logic [OFFSET_W-1:0] hit_k_c_o
);

   logic [WORD_W-1:0] match;

   for (genvar g = 0; g < WORD_W; g++) begin : g_cmp
      assign match[g] = (cat_i[g +: WORD_W] == MARKER);
   end

   // Priority encoder: scanning downward leaves the lowest match in place.
   always_comb begin
      hit_any_c_o = |match;
      hit_k_c_o   = '0;
      for (int k = int'(WORD_W) - 1; k >= 0; k--) begin
         if (match[k]) begin
            hit_k_c_o = OFFSET_W'(k);
         end
      end
   end

endmodule

// File: rtl/rx_word_aligner.sv
// Receive word aligner: hunts for a periodic marker, verifies and holds lock,
// and emits aligned 60-bit words with a 2-edge latency.
module rx_word_aligner
   import rx_align_pkg::*;
#(
   parameter logic [WORD_W-1:0] MARKER        = MARKER_DEFAULT,
   parameter int unsigned       MARKER_PERIOD = 16,
   parameter int unsigned       LOCK_CNT      = 3,
   parameter int unsigned       UNLOCK_CNT    = 4
) (
   input  logic                clk_div_60,
   input  logic                rst_n,
   input  logic [WORD_W-1:0]   data_in,
   output logic [WORD_W-1:0]   data_out,
   output logic                data_valid,
   output logic                marker_seen,
   output logic                lock,
   output logic [OFFSET_W-1:0] offset
);

   localparam int unsigned SLOT_W = (MARKER_PERIOD > 2) ? $clog2(MARKER_PERIOD) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(MARKER_PERIOD - 1);
   localparam logic [CNT_W-1:0]  LOCK_LIM   = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0]  UNLOCK_LIM = CNT_W'(UNLOCK_CNT);

   logic [WORD_W-1:0]   cur_q, prev_q;
   align_state_e        state_q, state_d;
   logic [OFFSET_W-1:0] offset_q, offset_d;
   logic [CNT_W-1:0]    hits_q, hits_d;
   logic [CNT_W-1:0]    misses_q, misses_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [WORD_W-1:0]   data_out_q, data_out_d;
   logic                data_valid_q, data_valid_d;
   logic                marker_seen_q, marker_seen_d;
   logic                lock_q, lock_d;

   logic [CAT_W-1:0]    cat;
   logic [WORD_W-1:0]   win_sel;
   logic                hit_any;
   logic [OFFSET_W-1:0] hit_k;
   logic                at_slot;
   logic                slot_hit;
   logic [SLOT_W-1:0]   slot_inc;
   logic [CNT_W-1:0]    hits_inc;
   logic [CNT_W-1:0]    misses_inc;

   assign cat        = {cur_q, prev_q};
   assign win_sel    = window_at(cat, offset_q);
   assign at_slot    = (slot_q == '0);
   assign slot_hit   = (win_sel == MARKER);
   assign slot_inc   = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
   assign hits_inc   = hits_q + CNT_W'(1);
   assign misses_inc = misses_q + CNT_W'(1);

   rx_marker_detector #(
      .MARKER (MARKER)
   ) u_detector (
      .cat_i       (cat),
      .hit_any_c_o (hit_any),
      .hit_k_c_o   (hit_k)
   );

   // Alignment FSM; VERIFY and LOCKED only look at the expected marker slot.
   always_comb begin
      state_d       = state_q;
      offset_d      = offset_q;
      hits_d        = hits_q;
      misses_d      = misses_q;
      slot_d        = slot_inc;
      marker_seen_d = 1'b0;

      unique case (state_q)
         HUNT: begin
            if (hit_any) begin
               offset_d = hit_k;
               hits_d   = CNT_W'(1);
               misses_d = '0;
               slot_d   = SLOT_W'(1);
               state_d  = (LOCK_CNT == 1) ? LOCKED : VERIFY;
            end
         end
         VERIFY: begin
            if (at_slot) begin
               if (slot_hit) begin
                  hits_d        = hits_inc;
                  marker_seen_d = 1'b1;
                  if (hits_inc == LOCK_LIM) begin
                     state_d  = LOCKED;
                     misses_d = '0;
                  end
               end else begin
                  hits_d  = '0;
                  state_d = HUNT;
               end
            end
         end
         LOCKED: begin
            if (at_slot) begin
               if (slot_hit) begin
                  misses_d      = '0;
                  marker_seen_d = 1'b1;
               end else begin
                  misses_d = misses_inc;
                  if (misses_inc == UNLOCK_LIM) begin
                     state_d  = HUNT;
                     hits_d   = '0;
                     misses_d = '0;
                  end
               end
            end
         end
         default: begin
            state_d = HUNT;
         end
      endcase

      data_out_d   = win_sel;
      data_valid_d = (state_q == LOCKED) && !at_slot;
      lock_d       = (state_d == LOCKED);
   end

   always_ff @(posedge clk_div_60 or negedge rst_n) begin
      if (!rst_n) begin
         cur_q         <= '0;
         prev_q        <= '0;
         state_q       <= HUNT;
         offset_q      <= '0;
         hits_q        <= '0;
         misses_q      <= '0;
         slot_q        <= '0;
         data_out_q    <= '0;
         data_valid_q  <= 1'b0;
         marker_seen_q <= 1'b0;
         lock_q        <= 1'b0;
      end else begin
         cur_q         <= data_in;
         prev_q        <= cur_q;
         state_q       <= state_d;
         offset_q      <= offset_d;
         hits_q        <= hits_d;
         misses_q      <= misses_d;
         slot_q        <= slot_d;
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
         marker_seen_q <= marker_seen_d;
         lock_q        <= lock_d;
      end
   end

   assign data_out    = data_out_q;
   assign data_valid  = data_valid_q;
   assign marker_seen = marker_seen_q;
   assign lock        = lock_q;
   assign offset      = offset_q;

endmodule
